vga_reg_fetch_sched: RTL and testbench

- Sequences the per-frame refresh of the display register bank from the shared 16x8 time/status RAM. This is the bank read by the VGA pointer logic: RTC seconds..years, chrono h/m/s, ring flag, active flag and cursor.
- Arbitrates the single RAM port between the frame-synchronous burst fetch and the RTC/keypad controller's write requests.
- Emits indexed shadow-register write strobes to the pointer block. The pointer block no longer fetches one register per frame.

---
 rtl/vga_reg_fetch_sched_pkg.sv | 40 ++++
 rtl/vga_reg_fetch_sched_frame_edge_detect.sv | 32 +++
 rtl/vga_reg_fetch_sched.sv | 160 ++++++++++++++++
 tb/tb_vga_reg_fetch_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_reg_fetch_sched_pkg.sv
// Shared display/time subsystem definitions: fetch FSM states, RAM map, screen geometry.
package vga_reg_fetch_sched_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    localparam int unsigned POS_W  = 10;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 2;

    // Time/status RAM map (address 0 is unused by the display bank)
    localparam int unsigned ADDR_SEG    = 1;
    localparam int unsigned ADDR_MIN    = 2;
    localparam int unsigned ADDR_HOR    = 3;
    localparam int unsigned ADDR_DAY    = 4;
    localparam int unsigned ADDR_MON    = 5;
    localparam int unsigned ADDR_YEAR   = 6;
    localparam int unsigned ADDR_CSEG   = 7;
    localparam int unsigned ADDR_CMIN   = 8;
    localparam int unsigned ADDR_CHOR   = 9;
    localparam int unsigned ADDR_RING   = 10;
    localparam int unsigned ADDR_ACT    = 11;
    localparam int unsigned ADDR_CURSOR = 12;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } fetch_state_e;

    // One shadow-register load: index plus raw RAM byte
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } shadow_wr_t;

endpackage

// File: rtl/vga_reg_fetch_sched_frame_edge_detect.sv
// Detects the rising edge of the start-of-vertical-blanking pixel position.
module vga_reg_fetch_sched_frame_edge_detect
    import vga_reg_fetch_sched_pkg::*;
#(
    parameter int unsigned V_START = SCREEN_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] pos_x,
    input  logic [POS_W-1:0] pos_y,
    output logic             trig_rise_c
);

    logic trig_d;
    logic trig_q;

    // Position compare; the position holds for several clocks so only the edge matters
    always_comb begin
        trig_d      = (pos_x == '0) && (pos_y == POS_W'(V_START));
        trig_rise_c = trig_d && !trig_q;
    end

    // Previous-cycle trigger level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_d;
        end
    end

endmodule

// File: rtl/vga_reg_fetch_sched.sv
// Per-frame burst refresh of the display shadow bank from the time/status RAM,
// sharing the single RAM port with RTC writes.
module vga_reg_fetch_sched
    import vga_reg_fetch_sched_pkg::*;
#(
    parameter int unsigned NREG    = 12,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned V_START = 480,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [POS_W-1:0]  PosX,
    input  logic [POS_W-1:0]  PosY,
    input  logic              rtc_req,
    input  logic [ADDR_W-1:0] rtc_addr,
    input  logic [DATA_W-1:0] rtc_wdata,
    output logic              rtc_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              shadow_wr,
    output logic [IDX_W-1:0]  shadow_idx,
    output logic [DATA_W-1:0] shadow_data,
    output logic              fetch_done,
    output logic              err_overrun
);

    fetch_state_e      state_q, state_d;
    logic              pending_q, pending_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    shadow_wr_t        shadow_q, shadow_d;
    logic              shadow_wr_q, shadow_wr_d;
    logic              fetch_done_q, fetch_done_d;
    logic              err_overrun_q, err_overrun_d;
    logic              trig_rise_c;

    vga_reg_fetch_sched_frame_edge_detect #(
        .V_START (V_START)
    ) u_edge (
        .clk         (CLK),
        .rst         (RESET),
        .pos_x       (PosX),
        .pos_y       (PosY),
        .trig_rise_c (trig_rise_c)
    );

    // RAM port mux: RTC owns the port whenever the fetcher is idle with nothing queued
    always_comb begin
        rtc_gnt   = (state_q == IDLE) && !pending_q;
        mem_we    = rtc_gnt && rtc_req;
        mem_addr  = rtc_gnt ? rtc_addr : mem_addr_q;
        mem_wdata = rtc_gnt ? rtc_wdata : '0;
    end

    // Trigger bookkeeping and burst sequencing
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        mem_addr_d    = mem_addr_q;
        shadow_d      = shadow_q;
        shadow_wr_d   = 1'b0;
        fetch_done_d  = 1'b0;
        err_overrun_d = err_overrun_q;

        if (trig_rise_c) begin
            if (state_q == IDLE) begin
                pending_d = 1'b1;
            end else begin
                err_overrun_d = 1'b1;
            end
        end

        // Last driven address is held once the RTC lets go of the port
        if (rtc_gnt && rtc_req) begin
            mem_addr_d = rtc_addr;
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    pending_d  = 1'b0;
                    idx_d      = IDX_W'(1);
                    mem_addr_d = ADDR_W'(1);
                    cnt_d      = '0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    shadow_d.idx  = idx_q;
                    shadow_d.data = mem_rdata;
                    shadow_wr_d   = 1'b1;
                    state_d       = NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NEXT: begin
                if (idx_q == IDX_W'(NREG)) begin
                    state_d = DONE;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    mem_addr_d = ADDR_W'(idx_q + IDX_W'(1));
                    state_d    = ADDR;
                end
            end
            DONE: begin
                fetch_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any burst in flight
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            idx_q         <= IDX_W'(1);
            cnt_q         <= '0;
            mem_addr_q    <= '0;
            shadow_q      <= '0;
            shadow_wr_q   <= 1'b0;
            fetch_done_q  <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            mem_addr_q    <= mem_addr_d;
            shadow_q      <= shadow_d;
            shadow_wr_q   <= shadow_wr_d;
            fetch_done_q  <= fetch_done_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    always_comb begin
        shadow_wr   = shadow_wr_q;
        shadow_idx  = shadow_q.idx;
        shadow_data = shadow_q.data;
        fetch_done  = fetch_done_q;
        err_overrun = err_overrun_q;
    end

endmodule

// File: tb/tb_vga_reg_fetch_sched.sv
// Bench for vga_reg_fetch_sched: RAM model, schedule-based reference model, directed scenarios.
module tb_vga_reg_fetch_sched;

    localparam int NREG   = 12;
    localparam int RD_LAT = 1;
    localparam int P      = RD_LAT + 2;
    localparam int L      = NREG * P;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [9:0] PosX, PosY;
    logic       rtc_req;
    logic [3:0] rtc_addr;
    logic [7:0] rtc_wdata;
    logic       rtc_gnt;
    logic [3:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       shadow_wr;
    logic [3:0] shadow_idx;
    logic [7:0] shadow_data;
    logic       fetch_done;
    logic       err_overrun;

    vga_reg_fetch_sched #(
        .NREG(NREG), .RD_LAT(RD_LAT), .V_START(480), .ADDR_W(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PosX(PosX), .PosY(PosY),
        .rtc_req(rtc_req), .rtc_addr(rtc_addr), .rtc_wdata(rtc_wdata), .rtc_gnt(rtc_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .shadow_wr(shadow_wr), .shadow_idx(shadow_idx), .shadow_data(shadow_data),
        .fetch_done(fetch_done), .err_overrun(err_overrun)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous RAM with RD_LAT-stage read pipeline
    logic       preload;
    logic [7:0] ram [16];
    logic [7:0] pipe [RD_LAT];
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'(8'h10 + i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        pipe[0] <= ram[mem_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[RD_LAT-1];

    // Stimulus-owned knobs read by the checker
    int       trig_cyc;
    logic [7:0] lit_d5;
    int       tmo;
    logic     fin_req;

    // Checker-owned state
    int checks = 0;
    int errors = 0;
    logic fin_done = 1'b0;
    logic [7:0] model_mem [16];
    int   burst_k = -1;
    logic err_exp = 1'b0;
    logic trig_prev = 1'b0;
    int   last_addr = 0;
    int   last_idx = 0;
    int   last_data = 0;
    int   obs_cnt = 0, obs_first_cyc = 0, obs_last_idx = 0;
    logic [7:0] obs_first_data = 0, obs_d5 = 0, obs_last_data = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    // Per-cycle compare against a schedule model derived from the burst timing rules
    always @(negedge CLK) begin
        int  n, rel, idxc, exp_addr;
        logic active, in_rng, exp_gnt, exp_wr, exp_done, rise, trig_now;
        if (RESET) begin
            chk("rst_shadow_wr", 32'(shadow_wr), 32'd0);
            chk("rst_shadow_idx", 32'(shadow_idx), 32'd0);
            chk("rst_shadow_data", 32'(shadow_data), 32'd0);
            chk("rst_fetch_done", 32'(fetch_done), 32'd0);
            chk("rst_err_overrun", 32'(err_overrun), 32'd0);
            chk("rst_rtc_gnt", 32'(rtc_gnt), 32'd1);
            chk("rst_mem_addr", 32'(mem_addr), 32'(rtc_addr));
            burst_k = -1; err_exp = 1'b0; trig_prev = 1'b0;
            last_addr = 0; last_idx = 0; last_data = 0; obs_cnt = 0;
            if (preload) for (int i = 0; i < 16; i++) model_mem[i] = 8'(8'h10 + i);
        end else begin
            n        = cyc;
            active   = (burst_k >= 0);
            rel      = n - burst_k;
            in_rng   = active && rel >= 1 && rel <= L + 1;
            exp_gnt  = !(active && rel >= 0 && rel <= L + 1);
            exp_done = active && rel == L + 2;
            exp_wr   = active && rel > 0 && (rel % P) == 0 && (rel / P) <= NREG;
            if (exp_wr) begin
                last_idx  = rel / P;
                last_data = int'(model_mem[rel / P]);
            end
            idxc = (rel - 1) / P + 1;
            if (idxc > NREG) idxc = NREG;
            exp_addr = exp_gnt ? int'(rtc_addr) : (in_rng ? idxc : last_addr);

            chk("rtc_gnt", 32'(rtc_gnt), 32'(exp_gnt));
            chk("mem_we", 32'(mem_we), 32'(exp_gnt && rtc_req));
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            if (exp_gnt && rtc_req) chk("mem_wdata", 32'(mem_wdata), 32'(rtc_wdata));
            chk("shadow_wr", 32'(shadow_wr), 32'(exp_wr));
            chk("shadow_idx", 32'(shadow_idx), 32'(last_idx));
            chk("shadow_data", 32'(shadow_data), 32'(last_data));
            chk("fetch_done", 32'(fetch_done), 32'(exp_done));
            chk("err_overrun", 32'(err_overrun), 32'(err_exp));

            // Observed burst log, pinned to hand-computed literals at completion
            if (shadow_wr) begin
                obs_cnt++;
                if (obs_cnt == 1) begin
                    obs_first_cyc  = n;
                    obs_first_data = shadow_data;
                end
                if (shadow_idx == 4'd5) obs_d5 = shadow_data;
                obs_last_data = shadow_data;
                obs_last_idx  = int'(shadow_idx);
            end
            if (fetch_done) begin
                chk("lit_nstrobe", 32'(obs_cnt), 32'd12);
                chk("lit_first_cyc", 32'(obs_first_cyc - trig_cyc), 32'd4);
                chk("lit_first_data", 32'(obs_first_data), 32'h11);
                chk("lit_d5", 32'(obs_d5), 32'(lit_d5));
                chk("lit_last_data", 32'(obs_last_data), 32'h1C);
                chk("lit_last_idx", 32'(obs_last_idx), 32'd12);
                chk("lit_done_cyc", 32'(n - trig_cyc), 32'd39);
                obs_cnt = 0;
            end

            // Advance model to the next cycle
            if (in_rng) last_addr = idxc;
            if (exp_gnt && rtc_req) begin
                model_mem[rtc_addr] = rtc_wdata;
                last_addr = int'(rtc_addr);
            end
            if (active && rel >= L + 2) burst_k = -1;
            trig_now  = (PosX == 10'd0) && (PosY == 10'd480);
            rise      = trig_now && !trig_prev;
            trig_prev = trig_now;
            if (rise) begin
                if (burst_k < 0) burst_k = n + 1;
                else if (rel != 0) err_exp = 1'b1;
            end
        end
        if (fin_req && !fin_done) begin
            chk("rtc_grant_bound", 32'(tmo), 32'd0);
            fin_done = 1'b1;
        end
    end

    // Hold the frame-start position for four clocks
    task automatic trig(input logic record);
        if (record) trig_cyc = cyc;
        PosX = 10'd0;
        PosY = 10'd480;
        repeat (4) @(posedge CLK);
        #1;
        PosY = 10'd0;
    endtask

    // Single RTC write, held until granted (bounded)
    task automatic do_rtc(input logic [3:0] a, input logic [7:0] d);
        logic got;
        got = 1'b0;
        rtc_addr  = a;
        rtc_wdata = d;
        rtc_req   = 1'b1;
        for (int t = 0; t < 80; t++) begin
            @(negedge CLK);
            if (rtc_gnt) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) tmo++;
        @(posedge CLK);
        #1;
        rtc_req = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; preload = 1'b1;
        PosX = 10'd5; PosY = 10'd0;
        rtc_req = 1'b0; rtc_addr = 4'd0; rtc_wdata = 8'd0;
        lit_d5 = 8'h15; trig_cyc = 0; tmo = 0; fin_req = 1'b0;
        idle(3);
        preload = 1'b0; RESET = 1'b0;
        idle(3);

        // Plain burst from preloaded RAM
        trig(1'b1);
        idle(45);

        // Idle RTC write to address 5, visible in the next burst
        do_rtc(4'd5, 8'h07);
        idle(2);
        lit_d5 = 8'h07;
        trig(1'b1);
        idle(45);

        // RTC request arriving mid-burst waits for the burst to finish
        fork
            trig(1'b1);
            begin
                idle(2);
                do_rtc(4'd3, 8'h33);
            end
        join
        idle(5);

        // RTC request coincident with the trigger edge
        fork
            trig(1'b1);
            do_rtc(4'd2, 8'h22);
        join
        idle(45);

        // Second trigger mid-burst: sticky overrun, burst unaffected, cleared by reset
        trig(1'b1);
        idle(11);
        trig(1'b0);
        idle(40);
        RESET = 1'b1;
        idle(2);
        RESET = 1'b0;
        idle(3);

        // Reset after the fifth strobe aborts the burst; next trigger runs in full
        trig(1'b1);
        idle(13);
        RESET = 1'b1;
        idle(2);
        RESET = 1'b0;
        idle(5);
        trig(1'b1);
        idle(45);

        fin_req = 1'b1;
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
